// File: rtl/pipelined_shifter_pkg.sv
// Shared types and sizing helpers for the pipelined barrel shifter.
// The optional SHIFT_FLAGS_EN build uses no extra package content.
package shifter_pkg;

    typedef enum logic [2:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } shift_op_e;

    function automatic int stage_count(input int width);
        return $clog2(width);
    endfunction

    function automatic int slot_count(input int stages, input int per_slot);
        return (stages + per_slot - 1) / per_slot;
    endfunction

endpackage

// File: rtl/pipelined_shifter_if.sv
// Operand/result handshake bundle for pipelined_shifter.
// out_zero/out_carry exist only when SHIFT_FLAGS_EN is defined.
interface pipelined_shifter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    localparam int AMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [AMT_W-1:0]   in_amt;
    logic [2:0]         in_op;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;
`ifdef SHIFT_FLAGS_EN
    logic               out_zero;
    logic               out_carry;
`endif

    modport master (
        output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
`ifdef SHIFT_FLAGS_EN
        input  out_zero, out_carry,
`endif
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
`ifdef SHIFT_FLAGS_EN
        output out_zero, out_carry,
`endif
        output in_ready, out_valid, out_data, out_tag
    );

endinterface

// File: rtl/pipelined_shifter_stage.sv
// One combinational barrel stage: shifts/rotates by 2**K when en is set.
// Carry tracking ports exist only when SHIFT_FLAGS_EN is defined.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int K     = 0
) (
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       op,
    input  logic             sign,
    input  logic             en,
`ifdef SHIFT_FLAGS_EN
    input  logic             carry_prev,
    output logic             carry,
`endif
    output logic [WIDTH-1:0] shifted
);
    localparam int SH = 2 ** K;

    // Illegal ops fall through the default and leave the operand untouched.
    always_comb begin
        shifted = data;
`ifdef SHIFT_FLAGS_EN
        carry = carry_prev;
`endif
        if (en) begin
            case (op)
                OP_SLL:  shifted = data << SH;
                OP_SRL:  shifted = data >> SH;
                OP_SRA:  shifted = (data >> SH) | ({WIDTH{sign}} << (WIDTH - SH));
                OP_ROL:  shifted = (data << SH) | (data >> (WIDTH - SH));
                OP_ROR:  shifted = (data >> SH) | (data << (WIDTH - SH));
                default: shifted = data;
            endcase
`ifdef SHIFT_FLAGS_EN
            case (op)
                OP_SLL, OP_ROL:         carry = data[WIDTH-SH];
                OP_SRL, OP_SRA, OP_ROR: carry = data[SH-1];
                default:                carry = carry_prev;
            endcase
`endif
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined multi-mode barrel shifter with per-slot valid/ready backpressure.
// Define SHIFT_FLAGS_EN to add registered out_zero/out_carry result flags.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 5
) (
    input  logic clk,
    input  logic rst,
    pipelined_shifter_if.slave bus
);
    localparam int S     = stage_count(WIDTH);
    localparam int P     = slot_count(S, REG_EVERY);
    localparam int AMT_W = S;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [AMT_W-1:0] amt;
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
        logic             sign;
`ifdef SHIFT_FLAGS_EN
        logic             carry;
`endif
    } slot_t;

    slot_t [P-1:0] slot_q;
    logic  [P-1:0] valid_q;
    logic  [P-1:0] load;
    logic  [P-1:0] src_valid;
    slot_t         in_slot;
    slot_t         st_in  [S];
    slot_t         st_out [S];
    slot_t         slot_d [P];
`ifdef SHIFT_FLAGS_EN
    logic          zero_q;
`endif

    always_comb begin
        in_slot      = '0;
        in_slot.data = bus.in_data;
        in_slot.amt  = bus.in_amt;
        in_slot.op   = bus.in_op;
        in_slot.tag  = bus.in_tag;
        in_slot.sign = bus.in_data[WIDTH-1];
    end

    // Stage k reads a slot register at every REG_EVERY boundary, else the previous stage.
    for (genvar k = 0; k < S; k++) begin : g_stage
        logic [WIDTH-1:0] shifted;
`ifdef SHIFT_FLAGS_EN
        logic             carry;
`endif
        if (k % REG_EVERY == 0) begin : g_head
            if (k == 0) begin : g_first
                assign st_in[k] = in_slot;
            end else begin : g_reg
                assign st_in[k] = slot_q[k/REG_EVERY - 1];
            end
        end else begin : g_chain
            assign st_in[k] = st_out[k-1];
        end

        shift_stage #(.WIDTH(WIDTH), .K(k)) u_stage (
            .data       (st_in[k].data),
            .op         (st_in[k].op),
            .sign       (st_in[k].sign),
            .en         (st_in[k].amt[k]),
`ifdef SHIFT_FLAGS_EN
            .carry_prev (st_in[k].carry),
            .carry      (carry),
`endif
            .shifted    (shifted)
        );

        always_comb begin
            st_out[k]      = st_in[k];
            st_out[k].data = shifted;
`ifdef SHIFT_FLAGS_EN
            st_out[k].carry = carry;
`endif
        end
    end

    // A slot may load unless it and every slot downstream are full with no drain.
    for (genvar j = 0; j < P; j++) begin : g_slot
        localparam int LAST = (((j + 1) * REG_EVERY < S) ? (j + 1) * REG_EVERY : S) - 1;
        assign slot_d[j] = st_out[LAST];
        assign load[j]   = bus.out_ready | ~(&valid_q[P-1:j]);
        if (j == 0) begin : g_src_in
            assign src_valid[j] = bus.in_valid;
        end else begin : g_src_slot
            assign src_valid[j] = valid_q[j-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            slot_q  <= '0;
        end else begin
            for (int j = 0; j < P; j++) begin
                if (load[j]) begin
                    valid_q[j] <= src_valid[j];
                    if (src_valid[j]) begin
                        slot_q[j] <= slot_d[j];
                    end
                end
            end
        end
    end

`ifdef SHIFT_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (load[P-1] && src_valid[P-1]) begin
            zero_q <= (slot_d[P-1].data == '0);
        end
    end

    assign bus.out_zero  = zero_q;
    assign bus.out_carry = slot_q[P-1].carry;
`endif

    assign bus.in_ready  = !rst & load[0];
    assign bus.out_valid = valid_q[P-1];
    assign bus.out_data  = slot_q[P-1].data;
    assign bus.out_tag   = slot_q[P-1].tag;

    // Already-consumed amount bits and the final slot's control fields are dead by design.
    logic unused_slot_bits;
    assign unused_slot_bits = ^slot_q;

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
Parametrised, pipelined multi-mode barrel shifter: the successor to the single-cycle combinational SLL shifter. It supports logical left/right, arithmetic right, and rotate left/right over a generic WIDTH. Operands move through log2(WIDTH) shift stages, with registers inserted every REG_EVERY stages and a valid/ready handshake with per-stage backpressure. It sits between the decode/issue logic and the writeback path of the multi-cycle datapath.

Parameters:
WIDTH, 32, data width; power of 2, 8..64.
REG_EVERY, 2, number of shift stages per pipeline register; 1..log2(WIDTH).
TAG_W, 5, width of the sideband tag carried alongside the data (e.g. rd index).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous active-high reset.
in_valid  in  1  input operand valid.
in_ready  out  1  block can accept the input this cycle.
in_data  in  WIDTH  operand.
in_amt  in  $clog2(WIDTH)  shift amount.
in_op  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; 101-111 illegal.
in_tag  in  TAG_W  sideband; returned unchanged.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_data  out  WIDTH  result.
out_tag  out  TAG_W  tag of this result.

Behaviour:
- Reset and clocking: one clock; reset is synchronous and active-high. While rst=1, every valid register clears, data/tag registers clear to 0, out_valid=0 and in_ready=0. Reset mid-operation discards all in-flight results; none reappear after reset.
- Depth and latency: S = log2(WIDTH) shift stages; stage k shifts by 2^k when amt bit k=1. P = ceil(S/REG_EVERY) register slots. Latency is P cycles from the in_valid&in_ready edge to out_valid (32/2 gives 3). Throughput is 1 per cycle with no stall.
- Handshake:
  - Transfer occurs on valid&ready at a clock edge.
  - Slot i loads when it is empty or slot i+1 loads (or, for the last slot, out_ready=1).
  - in_ready = !rst & (slot0 empty | slot0 advancing); bubbles collapse.
  - out_valid and out_data/out_tag are registered and held stable while out_valid=1 and out_ready=0.
- Mode semantics, per slot (op/amt/tag/a sign bit are carried with the data):
  - SLL and SRL fill vacated bits with 0.
  - SRA fills with the original in_data[WIDTH-1].
  - ROL and ROR wrap vacated bits around.
- Arithmetic rules:
  - in_amt=0 returns in_data unchanged for every op.
  - in_amt is unsigned; the max amount is WIDTH-1, and no amount aliases any other.
  - Illegal op: out_data=in_data (pass-through); the tag is still returned.
- Order is strictly preserved. A simultaneous out_ready and in_valid at full occupancy transfers both in the same cycle.

Optional Feature:
SHIFT_FLAGS_EN
- Defined: adds outputs out_zero (1) and out_carry (1), registered alongside out_data.
  - out_zero = (out_data==0).
  - out_carry is the last bit shifted out: SLL/ROL use in_data[WIDTH-amt]; SRL/SRA/ROR use in_data[amt-1]; 0 when amt=0 or op is illegal.
- Undefined: the ports and the carry tracking logic are absent; the remaining behaviour is identical.

Decomposition:
- Package shifter_pkg:
  - typedef enum logic [2:0] shift_op_e {OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR}.
  - Function for the stage count.
  - Slot struct: data, amt, op, tag, sign, carry.
- Sub-module shift_stage:
  - Purely combinational single 2^k shift, parametrised by WIDTH and K, handling all ops.
  - The top instantiates S of these in a generate loop and places registers every REG_EVERY.

Test Plan:
- (WIDTH=32, REG_EVERY=2) After reset, release rst, in_valid for one cycle with SLL 0x0000_0001 amt=31 tag=7 -> out_valid exactly 3 cycles later, out_data=0x8000_0000, out_tag=7.
- SRA 0x8000_0000 amt=4 -> 0xF800_0000. SRL on the same input -> 0x0800_0000. ROR 0x0000_00F1 amt=4 -> 0x1000_000F. ROL 0x8000_0001 amt=1 -> 0x0000_0003.
- Stream 8 back-to-back ops with out_ready=1 -> 8 results on consecutive cycles, in order. Hold out_ready=0 -> in_ready drops after 3 accepts, out_data is stable, and none is lost once out_ready returns.
- amt=0 for all five ops on 0xDEAD_BEEF -> 0xDEAD_BEEF. Illegal op 3'b111 -> 0xDEAD_BEEF with its tag.
- Assert rst with 3 ops in flight -> out_valid=0 on the next edge, and no stale result appears after reset deasserts.
- With SHIFT_FLAGS_EN: SLL 0x8000_0000 amt=1 -> out_data=0, out_zero=1, out_carry=1. SRL 0x3 amt=1 -> out_carry=1, out_zero=0.
